// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register: issues loads/stores to a variable-latency
// data memory, stalls upstream while an access is outstanding, then registers WB signals.
module mem_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        MEM_M,
  input  logic [1:0]        WB_M,
  input  logic [DATA_W-1:0] ALUOut_M,
  input  logic [DATA_W-1:0] WriteData_M,
  input  logic [4:0]        WriteReg_M,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_M,
  output logic [1:0]        WB_W,
  output logic [DATA_W-1:0] ReadData_W,
  output logic [DATA_W-1:0] ALUOut_W,
  output logic [4:0]        WriteReg_W,
  output logic              misalign_exc,
  output logic              bus_err,
  output logic [1:0]        fsm_state
);

  // Request channel: a request transfers on a cycle where dmem_req_valid and
  // dmem_req_ready are both 1; once raised, valid and addr/we/wdata stay stable
  // until that transfer. The response channel has no ready: dmem_rsp_valid is
  // honoured only while waiting and marks completion of loads and stores alike.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        cnt;
  logic              timed_out;
  logic [DATA_W-1:0] hold;
  logic              mem_op;
  logic              illegal;
  logic              req;
  logic              stall;
  logic              rsp_take;
  logic              to_hit;

  assign mem_op  = MEM_M[1] ^ MEM_M[0];
  assign illegal = (MEM_M[1] & MEM_M[0]) | (mem_op & (ALUOut_M[1:0] != 2'b00));

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    stall     = 1'b0;
    rsp_take  = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !illegal) begin
          req       = 1'b1;
          stall     = 1'b1;
          state_nxt = dmem_req_ready ? WAIT : REQ;
        end
      end
      REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        if (dmem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem_rsp_valid) begin
          rsp_take  = 1'b1;
          state_nxt = DONE;
        end else if (cnt == TIMEOUT_CNT) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset gates the combinational outputs so an aborted access disappears at once.
  assign dmem_req_valid = req & ~reset;
  assign stall_M        = stall & ~reset;
  assign dmem_we        = MEM_M[0];
  assign dmem_addr      = ALUOut_M;
  assign dmem_wdata     = WriteData_M;
  assign fsm_state      = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      timed_out <= 1'b0;
      hold      <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == WAIT) ? cnt + 8'd1 : 8'd0;
      if (rsp_take) hold <= dmem_rdata;
      if (to_hit) begin
        timed_out <= 1'b1;
      end else if (state != WAIT && state_nxt == WAIT) begin
        timed_out <= 1'b0;
      end
    end
  end

  // MEM/WB register; DONE has priority since stall is already low there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WB_W         <= 2'b00;
      ReadData_W   <= '0;
      ALUOut_W     <= '0;
      WriteReg_W   <= 5'd0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign_exc <= 1'b0;
      bus_err      <= to_hit;
      if (state == DONE) begin
        WB_W       <= timed_out ? 2'b00 : WB_M;
        ReadData_W <= timed_out ? '0 : hold;
        ALUOut_W   <= ALUOut_M;
        WriteReg_W <= WriteReg_M;
      end else if (stall) begin
        WB_W <= 2'b00;
      end else if (illegal) begin
        WB_W         <= 2'b00;
        misalign_exc <= 1'b1;
      end else begin
        WB_W       <= WB_M;
        ALUOut_W   <= ALUOut_M;
        WriteReg_W <= WriteReg_M;
        ReadData_W <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: randomized instruction stream with a memory responder and a
// transaction-level model predicting per-cycle outputs from chosen delays.
module tb_mem_wb_stage;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        MEM_M;
  logic [1:0]        WB_M;
  logic [DATA_W-1:0] ALUOut_M;
  logic [DATA_W-1:0] WriteData_M;
  logic [4:0]        WriteReg_M;
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_rsp_valid;
  logic [DATA_W-1:0] dmem_rdata;
  logic              stall_M;
  logic [1:0]        WB_W;
  logic [DATA_W-1:0] ReadData_W;
  logic [DATA_W-1:0] ALUOut_W;
  logic [4:0]        WriteReg_W;
  logic              misalign_exc;
  logic              bus_err;
  logic [1:0]        fsm_state;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .MEM_M(MEM_M), .WB_M(WB_M), .ALUOut_M(ALUOut_M),
    .WriteData_M(WriteData_M), .WriteReg_M(WriteReg_M),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata), .stall_M(stall_M), .WB_W(WB_W), .ReadData_W(ReadData_W),
    .ALUOut_W(ALUOut_W), .WriteReg_W(WriteReg_W), .misalign_exc(misalign_exc),
    .bus_err(bus_err), .fsm_state(fsm_state)
  );

  // Model state: expected outputs for the current cycle.
  logic              exp_stall, exp_req, exp_we;
  logic [DATA_W-1:0] exp_addr, exp_wdata;
  logic [1:0]        exp_wb;
  logic [DATA_W-1:0] exp_rd, exp_alu;
  logic [4:0]        exp_wr;
  logic              exp_mis, exp_bus;
  logic [64:0]       exp_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int stall_seen = 0;
  int mis_seen = 0;
  int bus_seen = 0;
  int hs_count = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard / compare process
  always @(negedge clk) begin
    if (chk_en) begin
      logic [64:0] item;
      check("stall_M", 64'(stall_M), 64'(exp_stall));
      check("dmem_req_valid", 64'(dmem_req_valid), 64'(exp_req));
      if (exp_req) begin
        check("dmem_we", 64'(dmem_we), 64'(exp_we));
        check("dmem_addr", 64'(dmem_addr), 64'(exp_addr));
        check("dmem_wdata", 64'(dmem_wdata), 64'(exp_wdata));
      end
      check("WB_W", 64'(WB_W), 64'(exp_wb));
      check("ReadData_W", 64'(ReadData_W), 64'(exp_rd));
      check("ALUOut_W", 64'(ALUOut_W), 64'(exp_alu));
      check("WriteReg_W", 64'(WriteReg_W), 64'(exp_wr));
      check("misalign_exc", 64'(misalign_exc), 64'(exp_mis));
      check("bus_err", 64'(bus_err), 64'(exp_bus));
      if (stall_M === 1'b1) stall_seen++;
      if (misalign_exc === 1'b1) mis_seen++;
      if (bus_err === 1'b1) bus_seen++;
      if (dmem_req_valid === 1'b1 && dmem_req_ready === 1'b1) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_req: got handshake addr %0h expected none", dmem_addr);
        end else begin
          item = exp_q.pop_front();
          check("req_we", 64'(dmem_we), 64'(item[64]));
          check("req_addr", 64'(dmem_addr), 64'(item[63:32]));
          check("req_wdata", 64'(dmem_wdata), 64'(item[31:0]));
        end
      end
    end
  end

  // Drives one instruction and acts as memory. rdy_d: cycles with ready low before
  // acceptance; rsp_d: response on the rsp_d-th wait cycle, or <=0 for no response.
  task automatic run_instr(input logic [1:0] mem, input logic [1:0] wb,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] wr, input int rdy_d, input int rsp_d,
                           input logic [31:0] rdv);
    bit is_mem, bad, legal;
    int n_req, n_stall;
    is_mem  = (mem == 2'b01) || (mem == 2'b10);
    bad     = (mem == 2'b11) || (is_mem && alu[1:0] != 2'b00);
    legal   = is_mem && !bad;
    n_req   = 1 + rdy_d;
    n_stall = legal ? n_req + ((rsp_d > 0) ? rsp_d : TIMEOUT + 1) : 0;
    MEM_M = mem; WB_M = wb; ALUOut_M = alu; WriteData_M = wd; WriteReg_M = wr;
    exp_we = mem[0]; exp_addr = alu; exp_wdata = wd;
    if (legal) exp_q.push_back({mem[0], alu, wd});
    for (int c = 0; c <= n_stall; c++) begin
      exp_stall = legal && (c < n_stall);
      exp_req   = legal && (c < n_req);
      if (legal && c < n_req) dmem_req_ready = (c == n_req - 1);
      else dmem_req_ready = 1'($urandom_range(0, 1));
      if (legal && rsp_d > 0 && c == n_req + rsp_d - 1) begin
        dmem_rsp_valid = 1'b1; dmem_rdata = rdv;
      end else if (legal && c >= n_req && c < n_stall) begin
        dmem_rsp_valid = 1'b0; dmem_rdata = $urandom;
      end else begin
        dmem_rsp_valid = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
      end
      @(posedge clk); #1;
      exp_mis = 1'b0;
      exp_bus = 1'b0;
      if (bad) begin
        exp_wb = 2'b00; exp_mis = 1'b1;
      end else if (!legal) begin
        exp_wb = wb; exp_alu = alu; exp_wr = wr; exp_rd = '0;
      end else if (c < n_stall) begin
        exp_wb = 2'b00;
        if (rsp_d <= 0 && c == n_stall - 1) exp_bus = 1'b1;
      end else begin
        exp_wb  = (rsp_d > 0) ? wb : 2'b00;
        exp_rd  = (rsp_d > 0) ? rdv : '0;
        exp_alu = alu; exp_wr = wr;
      end
    end
  endtask

  task automatic nop();
    run_instr(2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
  endtask

  initial begin
    int s0, h0, m0, b0;
    reset = 1'b1;
    MEM_M = 2'b00; WB_M = 2'b00; ALUOut_M = '0; WriteData_M = '0; WriteReg_M = 5'd0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    exp_wb = 2'b00; exp_rd = '0; exp_alu = '0; exp_wr = 5'd0; exp_mis = 1'b0; exp_bus = 1'b0;
    chk_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;

    // ALU op
    s0 = stall_seen;
    run_instr(2'b00, 2'b10, 32'h1234, 32'h0, 5'd5, 0, 0, 32'h0);
    check("t1_WB_W", 64'(WB_W), 64'h2);
    check("t1_ALUOut_W", 64'(ALUOut_W), 64'h1234);
    check("t1_WriteReg_W", 64'(WriteReg_W), 64'd5);
    check("t1_stalls", 64'(stall_seen - s0), 64'd0);

    // Load, immediate accept, response one cycle later
    s0 = stall_seen;
    run_instr(2'b10, 2'b11, 32'h40, 32'h0, 5'd7, 0, 1, 32'hDEADBEEF);
    check("t2_stalls", 64'(stall_seen - s0), 64'd2);
    check("t2_WB_W", 64'(WB_W), 64'h3);
    check("t2_ReadData_W", 64'(ReadData_W), 64'hDEADBEEF);

    // Store with ready low for 3 cycles
    s0 = stall_seen; h0 = hs_count;
    run_instr(2'b01, 2'b00, 32'h80, 32'hCAFEF00D, 5'd0, 3, 2, 32'h0);
    check("t3_handshakes", 64'(hs_count - h0), 64'd1);
    check("t3_stalls", 64'(stall_seen - s0), 64'd6);

    // Misaligned load, then MemRead&MemWrite
    s0 = stall_seen; h0 = hs_count; m0 = mis_seen;
    run_instr(2'b10, 2'b11, 32'h41, 32'h0, 5'd3, 0, 1, 32'h0);
    check("t4_WB_W", 64'(WB_W), 64'h0);
    nop();
    run_instr(2'b11, 2'b11, 32'h40, 32'h0, 5'd3, 0, 1, 32'h0);
    check("t4b_WB_W", 64'(WB_W), 64'h0);
    nop();
    check("t4_misalign_pulses", 64'(mis_seen - m0), 64'd2);
    check("t4_stalls", 64'(stall_seen - s0), 64'd0);
    check("t4_handshakes", 64'(hs_count - h0), 64'd0);

    // Timeout
    s0 = stall_seen; b0 = bus_seen;
    run_instr(2'b10, 2'b11, 32'h100, 32'h0, 5'd9, 1, 0, 32'h0);
    check("t5_WB_W", 64'(WB_W), 64'h0);
    check("t5_ReadData_W", 64'(ReadData_W), 64'h0);
    check("t5_bus_err_pulses", 64'(bus_seen - b0), 64'd1);
    check("t5_stalls", 64'(stall_seen - s0), 64'(2 + TIMEOUT + 1));

    // Randomized stream
    for (int i = 0; i < 200; i++) begin
      int k;
      logic [1:0]  mem;
      logic [31:0] alu;
      k = $urandom_range(0, 9);
      alu = $urandom;
      if (k < 4) begin
        mem = 2'b00;
      end else if (k < 8) begin
        mem = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
        alu[1:0] = 2'b00;
      end else begin
        mem = 2'($urandom_range(1, 3));
        if (mem != 2'b11) alu[1:0] = 2'($urandom_range(1, 3));
      end
      run_instr(mem, 2'($urandom_range(0, 3)), alu, $urandom, 5'($urandom_range(0, 31)),
                $urandom_range(0, 3), $urandom_range(1, 4), $urandom);
    end

    // Reset while waiting for a response
    MEM_M = 2'b10; WB_M = 2'b11; ALUOut_M = 32'h200; WriteData_M = 32'h0; WriteReg_M = 5'd4;
    exp_we = 1'b0; exp_addr = 32'h200; exp_wdata = 32'h0;
    exp_q.push_back({1'b0, 32'h200, 32'h0});
    exp_stall = 1'b1; exp_req = 1'b1;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    exp_req = 1'b0; exp_wb = 2'b00; exp_mis = 1'b0; exp_bus = 1'b0;
    dmem_req_ready = 1'b0;
    @(negedge clk); #1;
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_stall_M", 64'(stall_M), 64'h0);
    check("t6_req_valid", 64'(dmem_req_valid), 64'h0);
    check("t6_WB_W", 64'(WB_W), 64'h0);
    check("t6_ReadData_W", 64'(ReadData_W), 64'h0);
    check("t6_ALUOut_W", 64'(ALUOut_W), 64'h0);
    check("t6_WriteReg_W", 64'(WriteReg_W), 64'h0);
    check("t6_misalign", 64'(misalign_exc), 64'h0);
    check("t6_bus_err", 64'(bus_err), 64'h0);
    MEM_M = 2'b00; WB_M = 2'b00; ALUOut_M = '0; WriteReg_M = 5'd0;
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_wb = 2'b00; exp_rd = '0; exp_alu = '0;
    exp_wr = 5'd0; exp_mis = 1'b0; exp_bus = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    run_instr(2'b10, 2'b11, 32'h300, 32'h0, 5'd6, 0, 2, 32'h13572468);
    check("t6_after_ReadData_W", 64'(ReadData_W), 64'h13572468);
    check("t6_after_WB_W", 64'(WB_W), 64'h3);
    nop();

    check("req_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
